// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE
  } mdu_state_e;

  function automatic logic is_div(mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_rem(mdu_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_a(mdu_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(mdu_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_divstep.sv
// Combinational restoring-division step retiring STEP quotient bits, MSB first.
module mdu_divstep #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);

  logic [XLEN:0]   t;
  logic [XLEN-1:0] r, q;

  always_comb begin
    t = '0;
    r = rem_i;
    q = quot_i;
    for (int k = 0; k < STEP; k++) begin
      t = {r, q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (t >= {1'b0, div_i}) begin
        t    = t - {1'b0, div_i};
        q[0] = 1'b1;
      end
      r = t[XLEN-1:0];
    end
    rem_o  = r;
    quot_o = q;
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Optional MDU_FAST_MUL_EN: single-cycle MUL* through a hardware multiplier.
module ex_muldiv
  import mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd
);

  localparam int N  = XLEN / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] NCNT = CW'(N);

  mdu_state_e        state_q;
  mdu_op_e           op_q, op;
  logic [2*XLEN-1:0] acc_q;     // mul: {partial hi, multiplier}; div: {rem, quot}
  logic [XLEN-1:0]   opnd_q;    // multiplicand or divisor magnitude
  logic              res_neg_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   data_q;
  logic [4:0]        rd_q;

  logic              a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res;
  logic [2*XLEN:0]   mtmp;
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mul_d, full;
  logic [XLEN-1:0]   rem_d, quot_d, mul_res, dval, div_res;

  assign op = mdu_op_e'(req_op);

  always_comb begin
    a_neg    = is_signed_a(op) && req_a[XLEN-1];
    b_neg    = is_signed_b(op) && req_b[XLEN-1];
    a_mag    = a_neg ? -req_a : req_a;
    b_mag    = b_neg ? -req_b : req_b;
    div_zero = (req_b == '0);
    div_ovf  = is_div(op) && is_signed_b(op) && (&req_b) &&
               (req_a == {1'b1, {(XLEN-1){1'b0}}});
    if (is_rem(op)) spec_res = div_zero ? req_a : '0;
    else            spec_res = div_zero ? '1 : req_a;
  end

  // Shift-add: add multiplicand into the high half when the current multiplier LSB is set.
  always_comb begin
    msum = '0;
    mtmp = {1'b0, acc_q};
    for (int k = 0; k < STEP; k++) begin
      if (mtmp[0]) begin
        msum = {1'b0, mtmp[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        mtmp[2*XLEN:XLEN] = msum;
      end
      mtmp = mtmp >> 1;
    end
    mul_d = mtmp[2*XLEN-1:0];
  end

  mdu_divstep #(.XLEN(XLEN), .STEP(STEP)) u_divstep (
    .rem_i  (acc_q[2*XLEN-1:XLEN]),
    .quot_i (acc_q[XLEN-1:0]),
    .div_i  (opnd_q),
    .rem_o  (rem_d),
    .quot_o (quot_d)
  );

  always_comb begin
    full    = res_neg_q ? -acc_q : acc_q;
    mul_res = (op_q == OP_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
    dval    = is_rem(op_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_res = res_neg_q ? -dval : dval;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  assign a_ext = {{XLEN{a_neg}}, req_a};
  assign b_ext = {{XLEN{b_neg}}, req_b};
  assign prod  = a_ext * b_ext;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      acc_q     <= '0;
      opnd_q    <= '0;
      res_neg_q <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      rd_q      <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          op_q  <= op;
          rd_q  <= req_rd;
          cnt_q <= NCNT;
          if (is_div(op)) begin
            if (div_zero || div_ovf) begin
              data_q  <= spec_res;
              state_q <= S_DONE;
            end else begin
              acc_q     <= {{XLEN{1'b0}}, a_mag};
              opnd_q    <= b_mag;
              res_neg_q <= is_rem(op) ? a_neg : (a_neg ^ b_neg);
              state_q   <= S_DIV;
            end
          end else begin
`ifdef MDU_FAST_MUL_EN
            data_q  <= (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            state_q <= S_DONE;
`else
            acc_q     <= {{XLEN{1'b0}}, b_mag};
            opnd_q    <= a_mag;
            res_neg_q <= a_neg ^ b_neg;
            state_q   <= S_MUL;
`endif
          end
        end
        S_MUL: begin
          acc_q <= mul_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= S_FIXUP;
        end
        S_DIV: begin
          acc_q <= {rem_d, quot_d};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          data_q  <= is_div(op_q) ? div_res : mul_res;
          state_q <= S_DONE;
        end
        S_DONE: if (resp_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !flush;
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_data  = data_q;
  assign resp_rd    = rd_q;

endmodule
